// File: rtl/dff_pipeline_if.sv
// Stream bundle for dff_pipeline: producer side, consumer side, flush and fill level.
// The slave modport is the pipeline's view; the master modport drives it.
interface dff_pipeline_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/dff_pipeline.sv
// Stallable DEPTH-stage register pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and a registered occupancy count.
module dff_pipeline #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  dff_pipeline_if.slave  bus
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] r;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             accept;
  logic             xfer;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Stage i can take a beat unless it and every stage downstream are full and the consumer stalls.
    assign r[i] = bus.out_ready || !(&v_q[DEPTH-1:i]);

    if (i == 0) begin : g_head
      always_comb begin
        v_d[0] = v_q[0];
        d_d[0] = d_q[0];
        if (r[0]) begin
          v_d[0] = bus.in_valid && !bus.flush;
          d_d[0] = bus.in_data;
        end
        if (bus.flush) begin
          v_d[0] = 1'b0;
        end
      end
    end else begin : g_body
      // Data only moves with a valid beat, so empty stages keep stale contents.
      always_comb begin
        v_d[i] = v_q[i];
        d_d[i] = d_q[i];
        if (r[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            d_d[i] = d_q[i-1];
          end
        end
        if (bus.flush) begin
          v_d[i] = 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
      end else begin
        v_q[i] <= v_d[i];
        d_q[i] <= d_d[i];
      end
    end
  end

  assign bus.in_ready = r[0] && !bus.flush && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = v_q[DEPTH-1] && bus.out_ready;

  always_comb begin
    occ_d = occ_q;
    if (bus.flush) begin
      occ_d = '0;
    end else if (accept && !xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!accept && xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_dff_pipeline.sv
// Bench for dff_pipeline: a beat-position model predicts every cycle of a DEPTH=4 and a DEPTH=1 instance.
module tb_dff_pipeline;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dff_pipeline_if #(.WIDTH(8), .DEPTH(4)) b4 ();
  dff_pipeline_if #(.WIDTH(8), .DEPTH(1)) b1 ();

  dff_pipeline #(.WIDTH(8), .DEPTH(4)) u_d4 (.clk(clk), .rst(rst), .bus(b4.slave));
  dff_pipeline #(.WIDTH(8), .DEPTH(1)) u_d1 (.clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct {
    logic [7:0] d;
    int         p;
  } beat_t;
  typedef struct {
    logic [7:0] d;
    int         c;
  } out_t;

  beat_t      mq[$];
  out_t       log_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         mdepth = 4;
  bit         sel = 1'b0;
  bit         after_rst = 1'b1;
  bit         ex_ir;
  logic       o_ir, o_ov;
  logic [7:0] o_od;
  int         o_occ;

  // One clock cycle: drive, observe, compare with the model, then advance the model.
  task automatic cycle(input bit r, input bit fl, input bit iv, input logic [7:0] id, input bit ordy);
    bit   mv[8];
    int   n;
    bit   ex_ov;
    bit   leave;
    @(negedge clk);
    cyc++;
    rst          = r;
    b4.flush     = sel ? 1'b0 : fl;
    b4.in_valid  = sel ? 1'b0 : iv;
    b4.in_data   = id;
    b4.out_ready = sel ? 1'b0 : ordy;
    b1.flush     = sel ? fl : 1'b0;
    b1.in_valid  = sel ? iv : 1'b0;
    b1.in_data   = id;
    b1.out_ready = sel ? ordy : 1'b0;
    #1;
    if (!sel) begin
      o_ir = b4.in_ready; o_ov = b4.out_valid; o_od = b4.out_data; o_occ = int'(b4.occupancy);
    end else begin
      o_ir = b1.in_ready; o_ov = b1.out_valid; o_od = b1.out_data; o_occ = int'(b1.occupancy);
    end

    n = mq.size();
    for (int k = 0; k < n; k++) begin
      if (k == 0) mv[k] = (mq[0].p == mdepth - 1) ? ordy : 1'b1;
      else        mv[k] = (mq[k-1].p != mq[k].p + 1) ? 1'b1 : mv[k-1];
    end
    ex_ov = (n > 0) && (mq[0].p == mdepth - 1);
    ex_ir = !r && !fl && ((n == 0) || (mq[n-1].p != 0) || mv[n-1]);

    total++;
    if (o_ir !== ex_ir) begin
      bad++;
      $display("FAIL in_ready cyc=%0d got=%0b exp=%0b", cyc, o_ir, ex_ir);
    end
    total++;
    if (o_ov !== ex_ov) begin
      bad++;
      $display("FAIL out_valid cyc=%0d got=%0b exp=%0b", cyc, o_ov, ex_ov);
    end
    total++;
    if (o_occ !== n) begin
      bad++;
      $display("FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, o_occ, n);
    end
    if (ex_ov) begin
      total++;
      if (o_od !== mq[0].d) begin
        bad++;
        $display("FAIL out_data cyc=%0d got=%0h exp=%0h", cyc, o_od, mq[0].d);
      end
    end else if (after_rst) begin
      total++;
      if (o_od !== 8'h00) begin
        bad++;
        $display("FAIL out_data_reset cyc=%0d got=%0h exp=00", cyc, o_od);
      end
    end

    if (o_ov === 1'b1 && ordy && !r) log_q.push_back('{o_od, cyc});

    if (r) begin
      mq.delete();
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      leave = ex_ov && mv[0];
      for (int k = 0; k < n; k++) begin
        if (mv[k] && !(k == 0 && leave)) mq[k].p = mq[k].p + 1;
      end
      if (leave) void'(mq.pop_front());
      if (iv && ex_ir) mq.push_back('{id, 0});
      if (fl) mq.delete();
    end
  endtask

  task automatic test_reset();
    cycle(1, 0, 1, 8'hFF, 1);
    cycle(1, 0, 1, 8'hFF, 1);
    cycle(0, 0, 0, 8'h00, 1);
    total++;
    if (o_ir !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%0b exp=1", o_ir);
    end
  endtask

  task automatic test_stream();
    int t0;
    log_q.delete();
    t0 = cyc + 1;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, 8'(i + 1), 1);
      if (i == 10) begin
        total++;
        if (o_occ !== 4) begin
          bad++;
          $display("FAIL stream_steady_occ got=%0d exp=4", o_occ);
        end
      end
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'h00, 1);
    total++;
    if (log_q.size() !== 16) begin
      bad++;
      $display("FAIL stream_count got=%0d exp=16", log_q.size());
    end
    for (int k = 0; k < 16 && k < log_q.size(); k++) begin
      total++;
      if (log_q[k].d !== 8'(k + 1) || log_q[k].c !== t0 + 4 + k) begin
        bad++;
        $display("FAIL stream_beat k=%0d got=%0h@%0d exp=%0h@%0d", k, log_q[k].d, log_q[k].c, k + 1, t0 + 4 + k);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx;
    idx = 0;
    log_q.delete();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 1, 8'hA0 + 8'(idx), 0);
      if (ex_ir) idx++;
    end
    total++;
    if (idx !== 4 || o_ir !== 1'b0) begin
      bad++;
      $display("FAIL bp_fill got_acc=%0d ready=%0b exp_acc=4 ready=0", idx, o_ir);
    end
    for (int i = 0; i < 12; i++) begin
      if (idx < 6) begin
        cycle(0, 0, 1, 8'hA0 + 8'(idx), 1);
        if (i == 0) begin
          total++;
          if (o_ir !== 1'b1 || o_occ !== 4) begin
            bad++;
            $display("FAIL bp_swap got_ready=%0b occ=%0d exp_ready=1 occ=4", o_ir, o_occ);
          end
        end
        if (ex_ir) idx++;
      end else begin
        cycle(0, 0, 0, 8'h00, 1);
      end
    end
    total++;
    if (log_q.size() !== 6) begin
      bad++;
      $display("FAIL bp_count got=%0d exp=6", log_q.size());
    end
    for (int k = 0; k < log_q.size() && k < 6; k++) begin
      total++;
      if (log_q[k].d !== 8'hA0 + 8'(k)) begin
        bad++;
        $display("FAIL bp_order k=%0d got=%0h exp=%0h", k, log_q[k].d, 8'hA0 + 8'(k));
      end
    end
  endtask

  task automatic test_bubble();
    log_q.delete();
    cycle(0, 0, 1, 8'h11, 0);
    cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h22, 0);
    cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0);
    total++;
    if (o_occ !== 2 || o_ir !== 1'b1 || o_ov !== 1'b1 || o_od !== 8'h11) begin
      bad++;
      $display("FAIL bubble_pack got occ=%0d ready=%0b ov=%0b od=%0h exp occ=2 ready=1 ov=1 od=11",
               o_occ, o_ir, o_ov, o_od);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1);
    total++;
    if (log_q.size() !== 2 || log_q[0].d !== 8'h11 || log_q[1].d !== 8'h22 || log_q[1].c !== log_q[0].c + 1) begin
      bad++;
      $display("FAIL bubble_drain got n=%0d (two consecutive beats 11,22 required)", log_q.size());
    end
  endtask

  task automatic test_flush();
    int t0;
    log_q.delete();
    cycle(0, 0, 1, 8'h31, 0);
    cycle(0, 0, 1, 8'h32, 0);
    cycle(0, 0, 1, 8'h33, 0);
    cycle(0, 1, 1, 8'h55, 0);
    total++;
    if (o_ir !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready got=%0b exp=0", o_ir);
    end
    cycle(0, 0, 0, 8'h00, 1);
    total++;
    if (o_ov !== 1'b0 || o_occ !== 0) begin
      bad++;
      $display("FAIL flush_empty got ov=%0b occ=%0d exp ov=0 occ=0", o_ov, o_occ);
    end
    t0 = cyc + 1;
    cycle(0, 0, 1, 8'h66, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'h00, 1);
    total++;
    if (log_q.size() !== 1 || log_q[0].d !== 8'h66 || log_q[0].c !== t0 + 4) begin
      bad++;
      $display("FAIL flush_after got n=%0d exp single 66 at cycle %0d", log_q.size(), t0 + 4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(0, ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
            8'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'h00, 1);
  endtask

  task automatic test_depth1();
    int t0;
    sel = 1'b1;
    mdepth = 1;
    cycle(1, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 0);
    log_q.delete();
    t0 = cyc + 1;
    cycle(0, 0, 1, 8'h01, 1);
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 1, 8'h02, 1);
    cycle(0, 0, 0, 8'h00, 1);
    total++;
    if (log_q.size() !== 2 || log_q[0].d !== 8'h01 || log_q[0].c !== t0 + 1 ||
        log_q[1].d !== 8'h02 || log_q[1].c !== t0 + 3) begin
      bad++;
      $display("FAIL d1_latency got n=%0d exp 01@%0d 02@%0d", log_q.size(), t0 + 1, t0 + 3);
    end
    cycle(0, 0, 1, 8'h03, 0);
    cycle(0, 0, 1, 8'h04, 0);
    total++;
    if (o_ir !== 1'b0) begin
      bad++;
      $display("FAIL d1_full_ready got=%0b exp=0", o_ir);
    end
    cycle(0, 0, 1, 8'h04, 1);
    cycle(0, 0, 0, 8'h00, 0);
    total++;
    if (o_occ !== 1 || o_od !== 8'h04) begin
      bad++;
      $display("FAIL d1_swap got occ=%0d od=%0h exp occ=1 od=04", o_occ, o_od);
    end
    for (int i = 0; i < 200; i++) begin
      cycle(0, ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
            8'($urandom), $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    b4.flush = 1'b0; b4.in_valid = 1'b0; b4.in_data = 8'h00; b4.out_ready = 1'b0;
    b1.flush = 1'b0; b1.in_valid = 1'b0; b1.in_data = 8'h00; b1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
